// File: rtl/scan_display_n.sv
// scan_display_n: parametrised multiplexed 7-segment scanner with prescaler, per-digit dp and blanking
//   clk_i    system clock, all state changes on posedge
//   rst_ni   synchronous active-low reset
//   en_i     scan enable; low holds position and blanks the display
//   data_i   hex nibble per digit, digit i = data_i[4*i+3:4*i]
//   dp_i     per-digit decimal point request
//   blank_i  per-digit segment suppression
//   sel_o    index of the digit currently driven
//   dig_o    active-low one-hot digit enable
//   seg_o    active-low segments {dp,g,f,e,d,c,b,a}
//   frame_o  one-cycle pulse on each step into digit 0
module scan_display_n #(
  parameter int DIGITS = 8,
  parameter int SEL_W  = 3,
  parameter int DIV    = 1,
  parameter int DIV_W  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blank_i,
  output logic [SEL_W-1:0]      sel_o,
  output logic [DIGITS-1:0]     dig_o,
  output logic [7:0]            seg_o,
  output logic                  frame_o
);
  localparam logic [7:0] HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d, nxt;
  logic [DIGITS-1:0] dig_q, dig_d;
  logic [7:0]        seg_q, seg_d, base;
  logic              frame_q, frame_d, tick;
  // Outputs are computed from the digit being stepped into, so dig/seg always match sel in the same cycle.
  always_comb begin
    tick    = en_i && cnt_q == DIV_W'(DIV - 1);
    nxt     = sel_q == SEL_W'(DIGITS - 1) ? '0 : sel_q + SEL_W'(1);
    base    = HEX[data_i[4*nxt +: 4]];
    cnt_d   = !en_i ? cnt_q : tick ? '0 : cnt_q + DIV_W'(1);
    sel_d   = tick ? nxt : sel_q;
    dig_d   = !en_i ? '1 : tick ? ~(DIGITS'(1) << nxt) : dig_q;
    seg_d   = !en_i ? 8'hFF : !tick ? seg_q :
              blank_i[nxt] ? 8'hFF : {base[7] & ~dp_i[nxt], base[6:0]};
    frame_d = tick && nxt == '0;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      sel_q   <= SEL_W'(DIGITS - 1);
      dig_q   <= '1;
      seg_q   <= 8'hFF;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end
  assign sel_o   = sel_q;
  assign dig_o   = dig_q;
  assign seg_o   = seg_q;
  assign frame_o = frame_q;
endmodule

// File: tb/tb_scan_display_n.sv
// tb_scan_display_n: directed checks of scan_display_n in 8-digit, 6-digit and prescaled configurations
module tb_scan_display_n;
  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [31:0] data8, data4;
  logic [23:0] data6;
  logic [7:0]  dp, blank;
  logic [2:0]  sel8, sel6, sel4;
  logic [7:0]  dig8, dig4, seg8, seg6, seg4;
  logic [5:0]  dig6;
  logic        frm8, frm6, frm4;
  int          n_chk = 0, n_pass = 0;
  logic [7:0]  hex_t [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  always #5 clk = ~clk;
  scan_display_n #(.DIGITS(8), .SEL_W(3), .DIV(1), .DIV_W(1)) u8 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .data_i(data8), .dp_i(dp), .blank_i(blank),
    .sel_o(sel8), .dig_o(dig8), .seg_o(seg8), .frame_o(frm8)
  );
  scan_display_n #(.DIGITS(6), .SEL_W(3), .DIV(1), .DIV_W(1)) u6 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .data_i(data6), .dp_i(6'h00), .blank_i(6'h00),
    .sel_o(sel6), .dig_o(dig6), .seg_o(seg6), .frame_o(frm6)
  );
  scan_display_n #(.DIGITS(8), .SEL_W(3), .DIV(4), .DIV_W(2)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .data_i(data4), .dp_i(8'h00), .blank_i(8'h00),
    .sel_o(sel4), .dig_o(dig4), .seg_o(seg4), .frame_o(frm4)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; en = 1'b1; dp = '0; blank = '0;
    data8 = 32'h76543210; data6 = 24'h543210; data4 = 32'h76543210;
    repeat (3) cyc();
    chk("rst8_sel", sel8, 7); chk("rst8_dig", dig8, 8'hFF);
    chk("rst8_seg", seg8, 8'hFF); chk("rst8_frame", frm8, 0);
    chk("rst6_sel", sel6, 5); chk("rst6_dig", dig6, 6'h3F);
    chk("rst4_sel", sel4, 7); chk("rst4_seg", seg4, 8'hFF);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk($sformatf("scan8_sel%0d", k), sel8, k % 8);
      chk($sformatf("scan8_dig%0d", k), dig8, ~(8'd1 << (k % 8)) & 8'hFF);
      chk($sformatf("scan8_seg%0d", k), seg8, hex_t[k % 8]);
      chk($sformatf("scan8_frame%0d", k), frm8, (k % 8) == 0);
      chk($sformatf("scan6_sel%0d", k), sel6, k % 6);
      chk($sformatf("scan6_dig%0d", k), dig6, ~(6'd1 << (k % 6)) & 6'h3F);
      chk($sformatf("scan6_frame%0d", k), frm6, (k % 6) == 0);
      chk($sformatf("div4_sel%0d", k), sel4, k < 3 ? 7 : k < 7 ? 0 : 1);
      chk($sformatf("div4_seg%0d", k), seg4, k < 3 ? 8'hFF : k < 7 ? 8'hC0 : 8'hF9);
      chk($sformatf("div4_frame%0d", k), frm4, k == 3);
    end
    data4 = 32'h765432A0;
    data8 = 32'h76543810; dp = 8'h04;
    cyc();
    chk("hold4_sel_a", sel4, 1); chk("hold4_seg_a", seg4, 8'hF9);
    chk("dp8_sel1", sel8, 1); chk("dp8_seg1", seg8, 8'hF9);
    cyc();
    chk("hold4_sel_b", sel4, 1); chk("hold4_seg_b", seg4, 8'hF9);
    chk("dp8_sel2", sel8, 2); chk("dp8_seg2", seg8, 8'h00); chk("dp8_dig2", dig8, 8'hFB);
    cyc();
    chk("tick4_sel", sel4, 2); chk("tick4_seg", seg4, 8'hA4);
    chk("dp8_sel3", sel8, 3); chk("dp8_seg3", seg8, 8'hB0);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk($sformatf("en0_sel%0d", k), sel8, 3);
      chk($sformatf("en0_dig%0d", k), dig8, 8'hFF);
      chk($sformatf("en0_seg%0d", k), seg8, 8'hFF);
      chk($sformatf("en0_frame%0d", k), frm8, 0);
      chk($sformatf("en0_sel4_%0d", k), sel4, 2);
      chk($sformatf("en0_dig4_%0d", k), dig4, 8'hFF);
    end
    en = 1'b1; blank = 8'h04;
    for (int k = 0; k < 7; k++) begin
      logic [2:0] es;
      logic [7:0] eg;
      es = 3'(4 + k);
      eg = k == 6 ? 8'hFF : hex_t[es];
      cyc();
      chk($sformatf("resume8_sel%0d", k), sel8, es);
      chk($sformatf("resume8_seg%0d", k), seg8, eg);
      chk($sformatf("resume8_dig%0d", k), dig8, ~(8'd1 << es) & 8'hFF);
      chk($sformatf("resume8_frame%0d", k), frm8, es == 0);
      chk($sformatf("resume4_sel%0d", k), sel4, k < 3 ? 2 : 3);
      chk($sformatf("resume4_dig%0d", k), dig4, k < 3 ? 8'hFF : 8'hF7);
    end
    chk("blank8_dig", dig8, 8'hFB);
    rst_n = 1'b0;
    cyc();
    chk("midrst8_sel", sel8, 7); chk("midrst8_dig", dig8, 8'hFF);
    chk("midrst8_seg", seg8, 8'hFF); chk("midrst8_frame", frm8, 0);
    chk("midrst6_sel", sel6, 5); chk("midrst4_sel", sel4, 7);
    rst_n = 1'b1; blank = '0; dp = '0;
    cyc();
    chk("rel8_sel", sel8, 0); chk("rel8_frame", frm8, 1); chk("rel8_dig", dig8, 8'hFE);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
